sdpram_fifo_ctrl: RTL and testbench
===================================

# sdpram_fifo_ctrl

Synchronous FIFO controller that acts as the initiator on both ports of the 1024×32 simple dual-port RAM. It turns a valid/ready push stream into port-A writes and port-B reads into a valid/ready pop stream, hiding the RAM's 1-cycle read latency behind a small output buffer. It sits between a producer and a consumer, with the RAM instantiated alongside it.

## Interface
Parameters:
- `AW`, 10, RAM address width; FIFO capacity `DEPTH = 2**AW`.
- `DW`, 32, data width.

Ports:
- `clk` in 1: clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous, active-low.
- `s_valid` in 1: push request.
- `s_data` in DW: push data.
- `s_ready` out 1: FIFO can accept a word.
- `m_valid` out 1: pop data available.
- `m_data` out DW: head-of-FIFO word.
- `m_ready` in 1: consumer takes the word.
- `count` out AW+1: total words held (0..DEPTH).
- `ram_wena` out 1: RAM port A write enable.
- `ram_addra` out AW: RAM port A address.
- `ram_dina` out DW: RAM port A write data.
- `ram_renb` out 1: RAM port B read enable.
- `ram_addrb` out AW: RAM port B address.
- `ram_doutb` in DW: RAM port B data, valid the cycle after the edge that sampled `ram_renb`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr` are AW bits and wrap modulo DEPTH.
  - `ram_cnt` counts words in RAM not yet read.
  - `inflight` (1 bit) marks a read issued last edge.
  - `obuf` is a 3-entry circular output buffer with `ob_cnt`.
- A push occurs when `s_valid && s_ready`.
  - `ram_wena=1`, `ram_addra=wr_ptr`, `ram_dina=s_data`, combinationally.
  - `wr_ptr++` and `ram_cnt++`.
- Read issue: `issue = (ram_cnt!=0) && (ob_cnt + inflight < 3)`, computed from registered state only.
  - `ram_renb=issue`, `ram_addrb=rd_ptr`.
  - On issue: `rd_ptr++`, `ram_cnt--`, `inflight<=1`; otherwise `inflight<=0`.
- When `inflight==1`, `ram_doutb` is written into `obuf` at the tail on that edge.
- `m_valid = (ob_cnt!=0)`; `m_data` is the obuf head.
  - A pop occurs when `m_valid && m_ready` and advances the head.
- `count = ram_cnt + inflight + ob_cnt`.
- `s_ready = (count < DEPTH)`, registered-state based.
- A simultaneous push, issue, capture and pop in one cycle is legal; every counter nets its increments and decrements.
- Read-during-write to the same address cannot occur:
  - an issue needs `ram_cnt!=0`, so `rd_ptr!=wr_ptr`;
  - otherwise the FIFO is full, so no push is possible.
- The 3-entry `obuf` plus the registered issue gives one pop per cycle sustained.

## Timing
- Reset (`rst==0` at an edge):
  - pointers, `ram_cnt`, `inflight` and `ob_cnt` go to 0;
  - `m_valid=0`, `s_ready=1` (from the cycle after), `count=0`;
  - `ram_wena=0`, `ram_renb=0`; all addresses and `ram_dina` are 0.
- Reset mid-operation discards all contents. `ram_doutb` for a read issued before reset is ignored.
- While `rst==0`, `s_ready`, `m_valid`, `ram_wena` and `ram_renb` are forced to 0.
- Latency: a word accepted at edge N into an otherwise empty FIFO:
  - is read at edge N+1;
  - is captured at N+2;
  - `m_valid=1` from edge N+2.
- `count` updates at the edge after each accept or pop.
- Full: `count==DEPTH` gives `s_ready=0`. A pop at edge K gives `s_ready=1` after K.
- Empty: `m_valid=0` and `m_data` holds its last value. Holding `m_ready` high while empty has no effect.
- `m_data`/`m_valid` stay stable while `m_valid && !m_ready`.
- Pointer wrap from DEPTH-1 to 0 is silent.

## Structure
- Shared package `sdpram_pkg`:
  - `AW_DEF=10`, `DW_DEF=32`, `OBUF_DEPTH=3`;
  - typedefs `addr_t` (logic [AW_DEF-1:0]) and `data_t`.
- One sub-module `fifo_obuf`: the 3-entry output buffer with push/pop/count, reusable as a skid buffer.
- A top-level wrapper connects `ram_*` to the existing `sdpram_if` instance driving `simple_dual_port_ram`.

## Test plan
1. Reset, then push 350 at edge 1 with `m_ready=0` → `m_valid=1`, `m_data=350` from edge 3; `count=1`; `ram_wena` asserted with `ram_addra=0`.
2. Push 350, 670, 961 back-to-back, then hold `m_ready=1` → pops in order 350, 670, 961, one per cycle; `count` goes 3, 2, 1, 0.
3. Push 1024 words with `m_ready=0` → `s_ready=0` and `count=1024`; the 1025th `s_valid` is not accepted. One pop → `s_ready=1` the next cycle.
4. Stream 3000 incrementing words with push and pop every cycle → sustained 1 word/cycle, pointers wrap at 1023→0, no data loss or reorder, `count` stays ≤ 3.
5. Random `m_ready` backpressure (50 %) over 500 words → `m_data` stable while stalled; output sequence equals input sequence.
6. Assert `rst=0` with `count=5` and a read in flight → next cycle `count=0`, `m_valid=0`, `ram_renb=0`. A following push of 42 is the first word popped.

Source files
------------

// File: rtl/sdpram_pkg.sv
// rtl/sdpram_pkg.sv - shared types and sizes for the RAM-backed FIFO controller
package sdpram_pkg;

    localparam int AW_DEF     = 10;
    localparam int DW_DEF     = 32;
    localparam int OBUF_DEPTH = 3;

    typedef logic [AW_DEF-1:0] addr_t;
    typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_obuf.sv
// rtl/fifo_obuf.sv - 3-entry circular output buffer, usable as a skid buffer
module fifo_obuf
    import sdpram_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    cnt_o
);

    logic [DW-1:0] mem_q [OBUF_DEPTH];
    logic [DW-1:0] last_q;
    logic [1:0]    hd_q, tl_q, cnt_q;
    logic [1:0]    hd_d, tl_d, cnt_d;
    logic          push_ok, pop_ok;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign pop_ok  = pop_i && (cnt_q != 2'd0);
    assign push_ok = push_i && ((cnt_q != 2'(OBUF_DEPTH)) || pop_ok);

    always_comb begin
        hd_d  = pop_ok  ? ptr_inc(hd_q) : hd_q;
        tl_d  = push_ok ? ptr_inc(tl_q) : tl_q;
        cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hd_q   <= '0;
            tl_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
            if (push_ok) begin
                mem_q[tl_q] <= push_data_i;
            end
            if (pop_ok) begin
                last_q <= mem_q[hd_q];
            end
        end
    end

    // When empty, present the most recently popped word so the output holds.
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = valid_o ? mem_q[hd_q] : last_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// rtl/sdpram_fifo_ctrl.sv - FIFO controller driving both ports of a simple dual-port RAM
module sdpram_fifo_ctrl
    import sdpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic          ram_renb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb
);

    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    ob_cnt;
    logic          ob_valid;
    logic [AW:0]   count_w;
    logic          push, issue, pop;

    assign count_w = ram_cnt_q + (AW+1)'(inflight_q) + (AW+1)'(ob_cnt);

    assign s_ready = rst && (count_w != (AW+1)'(DEPTH));
    assign push    = s_valid && s_ready;
    // Issue looks only at registered state; a same-cycle pop is not credited.
    assign issue   = rst && (ram_cnt_q != '0)
                     && (({1'b0, ob_cnt} + {2'b0, inflight_q}) < 3'(OBUF_DEPTH));
    assign m_valid = rst && ob_valid;
    assign pop     = m_valid && m_ready;

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        inflight_d = issue;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // A read issued before reset is dropped because reset clears inflight_q.
    fifo_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (ram_doutb),
        .pop_i       (pop),
        .valid_o     (ob_valid),
        .data_o      (m_data),
        .cnt_o       (ob_cnt)
    );

    assign count     = count_w;
    assign ram_wena  = push;
    assign ram_addra = wr_ptr_q;
    assign ram_dina  = push ? s_data : '0;
    assign ram_renb  = issue;
    assign ram_addrb = rd_ptr_q;

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb/tb_sdpram_fifo_ctrl.sv - randomized and directed bench with a queue reference model
module tb_sdpram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [AW:0]   count;
    logic          ram_wena;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          ram_renb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] model_q [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int            pop_total  = 0;

    sdpram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .ram_wena  (ram_wena),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_renb  (ram_renb),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wena) ram_mem[ram_addra] <= ram_dina;
        if (ram_renb) ram_doutb <= ram_mem[ram_addrb];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: a plain queue of accepted words; every pop must take the front.
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        if (!rst) begin
            check_eq("rst_s_ready", s_ready, 0);
            check_eq("rst_m_valid", m_valid, 0);
            check_eq("rst_wena", ram_wena, 0);
            check_eq("rst_renb", ram_renb, 0);
            model_q.delete();
            stall_prev = 1'b0;
        end else begin
            check_eq("mon_count", count, sz);
            check_eq("mon_s_ready", s_ready, (sz < DEPTH));
            check_eq("mon_wena", ram_wena, (s_valid && sz < DEPTH));
            if (m_valid) begin
                if (sz == 0) check_eq("mon_valid_empty", 1, 0);
                else         check_eq("mon_data", m_data, model_q[0]);
            end
            if (stall_prev) begin
                check_eq("mon_stall_valid", m_valid, 1);
                check_eq("mon_stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready && sz > 0) begin
                void'(model_q.pop_front());
                pop_total++;
            end
            if (s_valid && sz < DEPTH) model_q.push_back(s_data);
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 2200 && !done; i++) begin
            @(negedge clk);
            if (count == 0 && !m_valid) done = 1'b1;
            else step();
        end
        if (!done) check_eq("drain_timeout", 1, 0);
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_d [3];
        int            pops0, maxc, pushed;
        bit            seen;

        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_eq("reset_count", count, 0);
        check_eq("reset_addra", ram_addra, 0);
        check_eq("reset_addrb", ram_addrb, 0);
        check_eq("reset_dina", ram_dina, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_s_ready", s_ready, 1);
        step();

        // Single word latency
        s_valid = 1'b1; s_data = 350;
        @(negedge clk);
        check_eq("t1_wena", ram_wena, 1);
        check_eq("t1_addra", ram_addra, 0);
        check_eq("t1_dina", ram_dina, 350);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_count", count, 1);
        check_eq("t1_renb", ram_renb, 1);
        check_eq("t1_valid_n1", m_valid, 0);
        @(negedge clk);
        check_eq("t1_valid_n2", m_valid, 0);
        @(negedge clk);
        check_eq("t1_valid_n3", m_valid, 1);
        check_eq("t1_data", m_data, 350);
        step();
        drain();
        @(negedge clk);
        check_eq("t1_hold_data", m_data, 350);
        step();

        // Three words, then back-to-back pops
        exp_d[0] = 350; exp_d[1] = 670; exp_d[2] = 961;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = exp_d[i];
            step();
        end
        s_valid = 1'b0;
        repeat (5) step();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t2_valid", m_valid, 1);
            check_eq("t2_data", m_data, exp_d[i]);
            check_eq("t2_count", count, 3 - i);
            step();
        end
        @(negedge clk);
        check_eq("t2_count_end", count, 0);
        check_eq("t2_valid_end", m_valid, 0);
        step();
        m_ready = 1'b0;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1; s_data = 1000 + i;
            step();
        end
        s_data = 9999;
        @(negedge clk);
        check_eq("t3_s_ready_full", s_ready, 0);
        check_eq("t3_count_full", count, DEPTH);
        check_eq("t3_wena_full", ram_wena, 0);
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_s_ready_after_pop", s_ready, 1);
        check_eq("t3_count_after_pop", count, DEPTH - 1);
        step();
        drain();

        // Streaming, push and pop every cycle
        pops0 = pop_total; maxc = 0;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s_data = 32'(i);
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
            step();
        end
        s_valid = 1'b0;
        check_eq("t4_count_max_le3", (maxc <= 3), 1);
        check_eq("t4_rate", ((pop_total - pops0) >= 2997), 1);
        drain();

        // Random backpressure
        pushed = 0;
        for (int i = 0; i < 6000 && pushed < 500; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            m_ready = $urandom_range(0, 1);
            @(negedge clk);
            if (s_valid && s_ready) pushed++;
            step();
        end
        check_eq("t5_pushed", pushed, 500);
        drain();

        // Reset with contents and a read in flight
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 500 + i;
            step();
        end
        s_valid = 1'b0;
        repeat (6) step();
        s_valid = 1'b1; s_data = 505; m_ready = 1'b1;
        step();
        s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check_eq("t6_renb_pre", ram_renb, 1);
        step();
        check_eq("t6_count_pre", count, 5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_count", count, 0);
        check_eq("t6_m_valid", m_valid, 0);
        check_eq("t6_renb", ram_renb, 0);
        step();
        s_valid = 1'b1; s_data = 42;
        step();
        s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
            else step();
        end
        check_eq("t6_first_valid", seen, 1);
        check_eq("t6_first_data", m_data, 42);
        step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
